// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor:
// FSM state encoding, default widths and the error-distance function.
package approx_mult_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Unsigned |a - b|; the result always fits in the operand width.
  function automatic logic [2*DEF_W-1:0] abs_diff(input logic [2*DEF_W-1:0] a,
                                                  input logic [2*DEF_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/approx_err_dist.sv
// Two-stage pipeline: stage 1 registers operands and the exact product,
// stage 2 registers the error distance |exact - z| with the operands alongside.
module approx_err_dist
  import approx_mult_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [W-1:0]   i_x,
  input  logic [W-1:0]   i_y,
  input  logic [2*W-1:0] i_z,
  output logic           o_pend,
  output logic           o_valid,
  output logic [2*W-1:0] o_ed,
  output logic [W-1:0]   o_x,
  output logic [W-1:0]   o_y
);

  logic           r_v1;
  logic [W-1:0]   r_x1;
  logic [W-1:0]   r_y1;
  logic [2*W-1:0] r_z1;
  logic [2*W-1:0] r_exact1;
  logic           r_v2;
  logic [2*W-1:0] r_ed2;
  logic [W-1:0]   r_x2;
  logic [W-1:0]   r_y2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_z1     <= '0;
      r_exact1 <= '0;
      r_v2     <= 1'b0;
      r_ed2    <= '0;
      r_x2     <= '0;
      r_y2     <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_x1     <= i_x;
        r_y1     <= i_y;
        r_z1     <= i_z;
        r_exact1 <= {{W{1'b0}}, i_x} * {{W{1'b0}}, i_y};
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ed2 <= abs_diff(r_exact1, r_z1);
        r_x2  <= r_x1;
        r_y2  <= r_y1;
      end
    end
  end

  // o_pend flags a sample still in stage 1, i.e. not yet at the output.
  assign o_pend  = r_v1;
  assign o_valid = r_v2;
  assign o_ed    = r_ed2;
  assign o_x     = r_x2;
  assign o_y     = r_y2;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Scores an approximate multiplier: recomputes x*y, and over a programmed
// number of samples accumulates error count, saturating ED sum and max ED.
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [2*W-1:0]   z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic             sum_sat,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     max_x,
  output logic [W-1:0]     max_y,
  output state_e           dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready is registered from state/count only and never looks at in_valid.

  state_e           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_err;
  logic [ACC_W-1:0] r_sum;
  logic             r_sat;
  logic [2*W-1:0]   r_max_ed;
  logic [W-1:0]     r_max_x;
  logic [W-1:0]     r_max_y;

  logic             w_accept;
  logic             w_start;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_pend;
  logic             w_ed_valid;
  logic [2*W-1:0]   w_ed;
  logic [W-1:0]     w_ed_x;
  logic [W-1:0]     w_ed_y;
  logic [ACC_W:0]   w_sum_ext;

  assign w_accept   = in_valid & r_in_ready;
  assign w_start    = (r_state == ST_IDLE) & start;
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_sum_ext  = {1'b0, r_sum} + {{(ACC_W + 1 - 2*W){1'b0}}, w_ed};

  approx_err_dist #(.W(W)) u_err_dist (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept),
    .i_x     (x),
    .i_y     (y),
    .i_z     (z),
    .o_pend  (w_pend),
    .o_valid (w_ed_valid),
    .o_ed    (w_ed),
    .o_x     (w_ed_x),
    .o_y     (w_ed_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_num      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (num_samples != '0) begin
              r_num      <= num_samples;
              r_state    <= ST_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == r_num) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // No accepts happen here, so an empty stage 1 means the last sample is at the output.
          if (w_ed_valid && !w_pend) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= '0;
      r_sum    <= '0;
      r_sat    <= 1'b0;
      r_max_ed <= '0;
      r_max_x  <= '0;
      r_max_y  <= '0;
    end else if (w_start) begin
      r_err    <= '0;
      r_sum    <= '0;
      r_sat    <= 1'b0;
      r_max_ed <= '0;
      r_max_x  <= '0;
      r_max_y  <= '0;
    end else if (w_ed_valid) begin
      if (w_sum_ext[ACC_W]) begin
        r_sum <= '1;
        r_sat <= 1'b1;
      end else begin
        r_sum <= w_sum_ext[ACC_W-1:0];
      end
      if (w_ed != '0) r_err <= r_err + CNT_W'(1);
      // Strictly greater keeps the first sample that reached the maximum.
      if (w_ed > r_max_ed) begin
        r_max_ed <= w_ed;
        r_max_x  <= w_ed_x;
        r_max_y  <= w_ed_y;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err;
  assign sum_ed    = r_sum;
  assign sum_sat   = r_sat;
  assign max_ed    = r_max_ed;
  assign max_x     = r_max_x;
  assign max_y     = r_max_y;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Bench for approx_mult_err_monitor: a 32-bit and a 17-bit accumulator instance
// share one stimulus stream and are scored against a plain-arithmetic model.
module tb_approx_mult_err_monitor;
  import approx_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] z;

  logic        in_ready, busy, done, sum_sat;
  logic [15:0] err_count, max_ed;
  logic [31:0] sum_ed;
  logic [7:0]  max_x, max_y;
  state_e      dbg_state;

  logic        in_ready_s, busy_s, done_s, sum_sat_s;
  logic [15:0] err_count_s, max_ed_s;
  logic [16:0] sum_ed_s;
  logic [7:0]  max_x_s, max_y_s;
  state_e      dbg_state_s;

  int n_checks = 0;
  int n_fail   = 0;

  int          s_x[$];
  int          s_y[$];
  int          s_z[$];
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  approx_mult_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .err_count(err_count), .sum_ed(sum_ed),
    .sum_sat(sum_sat), .max_ed(max_ed), .max_x(max_x), .max_y(max_y),
    .dbg_state(dbg_state)
  );

  approx_mult_err_monitor #(.ACC_W(17)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .x(x), .y(y), .z(z),
    .busy(busy_s), .done(done_s), .err_count(err_count_s), .sum_ed(sum_ed_s),
    .sum_sat(sum_sat_s), .max_ed(max_ed_s), .max_x(max_x_s), .max_y(max_y_s),
    .dbg_state(dbg_state_s)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_samples();
    s_x.delete(); s_y.delete(); s_z.delete(); exp_q.delete();
  endtask

  task automatic add(input int sx, input int sy, input int sz);
    s_x.push_back(sx); s_y.push_back(sy); s_z.push_back(sz);
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    num_samples = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", longint'(busy), longint'(n != 0));
    chk("ready_after_start", longint'(in_ready), longint'(n != 0));
    chk("ready_after_start_s", longint'(in_ready_s), longint'(n != 0));
  endtask

  task automatic send_sample(input int sx, input int sy, input int sz);
    int waited = 0;
    int ed;
    x = 8'(sx); y = 8'(sy); z = 16'(sz);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("no_stall", longint'(waited), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ed = sx * sy - sz;
    if (ed < 0) ed = -ed;
    exp_q.push_back(16'(ed));
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_results(input string tag);
    longint tot = 0;
    longint lim32 = 64'hFFFF_FFFF;
    longint lim17 = (64'd1 << 17) - 1;
    int err = 0;
    int mx = 0;
    int ax = 0;
    int ay = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i] != 0) err++;
      tot += longint'(exp_q[i]);
      if (int'(exp_q[i]) > mx) begin
        mx = int'(exp_q[i]); ax = s_x[i]; ay = s_y[i];
      end
    end
    chk({tag, "_err"}, longint'(err_count), longint'(err));
    chk({tag, "_sum"}, longint'(sum_ed), (tot > lim32) ? lim32 : tot);
    chk({tag, "_sat"}, longint'(sum_sat), longint'(tot > lim32));
    chk({tag, "_max_ed"}, longint'(max_ed), longint'(mx));
    chk({tag, "_max_x"}, longint'(max_x), longint'(ax));
    chk({tag, "_max_y"}, longint'(max_y), longint'(ay));
    chk({tag, "_err_s"}, longint'(err_count_s), longint'(err));
    chk({tag, "_sum_s"}, longint'(sum_ed_s), (tot > lim17) ? lim17 : tot);
    chk({tag, "_sat_s"}, longint'(sum_sat_s), longint'(tot > lim17));
    chk({tag, "_max_ed_s"}, longint'(max_ed_s), longint'(mx));
  endtask

  task automatic run_samples(input string tag, input int gap);
    int n = s_x.size();
    int lat = 0;
    exp_q.delete();
    start_run(n);
    for (int i = 0; i < n; i++) begin
      send_sample(s_x[i], s_y[i], s_z[i]);
      if (i < n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    chk({tag, "_ready_drop"}, longint'(in_ready), 0);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_done_latency"}, longint'(lat), 2);
    chk({tag, "_done_s"}, longint'(done_s), 1);
    chk({tag, "_busy_at_done"}, longint'(busy), 0);
    check_results(tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, longint'(done), 0);
    chk({tag, "_idle"}, longint'(dbg_state), longint'(ST_IDLE));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_ready"}, longint'(in_ready), 0);
    chk({tag, "_done"}, longint'(done), 0);
    exp_q.delete();
    check_results(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; x = '0; y = '0; z = '0;
    repeat (3) @(posedge clk); #1;
    check_cleared("reset");
    chk("reset_state", longint'(dbg_state), longint'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    clear_samples();
    add(3, 5, 15); add(255, 255, 65025); add(0, 7, 0); add(16, 16, 256);
    run_samples("exact", 0);

    clear_samples();
    add(3, 5, 14); add(10, 10, 110); add(2, 2, 4);
    run_samples("errors", 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_err", longint'(err_count), 2);
    chk("hold_sum", longint'(sum_ed), 11);
    chk("hold_max_x", longint'(max_x), 10);

    clear_samples();
    add(4, 4, 18); add(2, 8, 14);
    run_samples("tie", 2);
    chk("tie_first_x", longint'(max_x), 4);

    clear_samples();
    start_run(0);
    chk("zero_done", longint'(done), 1);
    check_results("zero");
    @(posedge clk); #1;
    chk("zero_done_pulse", longint'(done), 0);
    chk("zero_ready", longint'(in_ready), 0);

    clear_samples();
    add(255, 255, 0); add(255, 255, 0); add(255, 255, 0);
    run_samples("sat", 1);
    chk("sat_flag_s", longint'(sum_sat_s), 1);
    chk("sat_sum_s", longint'(sum_ed_s), 131071);

    clear_samples();
    for (int i = 0; i < 5; i++) add(3, 5, 0);
    start_run(5);
    send_sample(3, 5, 0);
    send_sample(3, 5, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_err", longint'(err_count), 2);
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    check_cleared("midrst_next");
    @(posedge clk); #1;
    clear_samples();
    add(3, 5, 0); add(7, 9, 60);
    run_samples("after_rst", 0);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 8);
      clear_samples();
      for (int i = 0; i < n; i++) begin
        int ax = $urandom_range(0, 255);
        int ay = $urandom_range(0, 255);
        int az = ax * ay;
        case ($urandom_range(0, 2))
          0: az = ax * ay;
          1: az = ax * ay + $urandom_range(0, 40) - 20;
          default: az = $urandom_range(0, 65535);
        endcase
        if (az < 0) az = 0;
        if (az > 65535) az = 65535;
        add(ax, ay, az);
      end
      run_samples("rand", $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
